idct_2d: RTL and testbench



---
 rtl/idct_2d.sv | 164 ++++++++++++++++
 tb/tb_idct_2d.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/idct_2d.sv
// idct_2d: 8x8 inverse DCT using row-column decomposition through one shared
// 8-point 1-D IDCT datapath, with a transpose buffer between the passes.
// Optional feature macro: IDCT_CLIP_EN. When it is defined, column-pass results
// saturate to CLIP_BITS signed. This also adds the CLIP_BITS parameter.
module idct_2d #(
    parameter int unsigned COEF_FRAC_BITS = 12
`ifdef IDCT_CLIP_EN
    ,
    parameter int unsigned CLIP_BITS      = 11
`endif
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        INPUT_DATA_ENABLE,
    output logic        INPUT_READY,
    input  logic [31:0] INPUT_DATA [8][8],
    output logic        OUTPUT_DATA_ENABLE,
    output logic [31:0] OUTPUT_DATA [8][8]
);

    typedef enum logic [1:0] {StIdle, StRow, StCol, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] in_q   [8][8];
    logic [31:0] in_d   [8][8];
    logic [31:0] tbuf_q [8][8];
    logic [31:0] tbuf_d [8][8];
    logic [31:0] out_q  [8][8];
    logic [31:0] out_d  [8][8];
    logic [31:0] vec    [8];
    logic [31:0] res    [8];
    logic signed [47:0] acc, rnd;

    // Cosine table entry C[k][n].
    // The table values assume COEF_FRAC_BITS = 12.
    // Angles fold onto the first quadrant: m*pi/16 with m = (2n+1)k mod 32.
    function automatic logic signed [13:0] cos_coef(input int k, input int n);
        int m;
        logic neg;
        logic signed [13:0] mag;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       mag = 14'sd2048;
            1:       mag = 14'sd2009;
            2:       mag = 14'sd1892;
            3:       mag = 14'sd1703;
            4:       mag = 14'sd1448;
            5:       mag = 14'sd1138;
            6:       mag = 14'sd784;
            7:       mag = 14'sd400;
            default: mag = 14'sd0;
        endcase
        if (k == 0) return 14'sd1448;
        return neg ? -mag : mag;
    endfunction

`ifdef IDCT_CLIP_EN
    localparam int ClipMax = (1 <<< (CLIP_BITS - 1)) - 1;
    localparam int ClipMin = -(1 <<< (CLIP_BITS - 1));
`endif

    // Select the input vector for the shared 1-D datapath.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            vec[k] = (state_q == StCol) ? tbuf_q[cnt_q][k] : in_q[cnt_q][k];
        end
    end

    // Shared 1-D IDCT: MAC in 48 bits, round, arithmetic shift, wrap to 32 bits.
    always_comb begin
        acc = '0;
        rnd = '0;
        for (int n = 0; n < 8; n++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                acc = acc + $signed(vec[k]) * cos_coef(k, n);
            end
            rnd    = acc + (48'sd1 <<< (COEF_FRAC_BITS - 1));
            rnd    = rnd >>> COEF_FRAC_BITS;
            res[n] = rnd[31:0];
`ifdef IDCT_CLIP_EN
            if (state_q == StCol) begin
                if ($signed(res[n]) > ClipMax) res[n] = ClipMax;
                else if ($signed(res[n]) < ClipMin) res[n] = ClipMin;
            end
`endif
        end
    end

    // State, counter and all buffers, asynchronously cleared.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    in_q[i][j]   <= '0;
                    tbuf_q[i][j] <= '0;
                    out_q[i][j]  <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            tbuf_q  <= tbuf_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (INPUT_DATA_ENABLE) begin
                    state_d = StRow;
                    cnt_d   = '0;
                end
            end
            StRow: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = StCol;
            end
            StCol: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Buffer updates: capture in IDLE, row results go to tbuf column cnt,
    // and column results go to out column cnt.
    always_comb begin
        in_d   = in_q;
        tbuf_d = tbuf_q;
        out_d  = out_q;
        if (state_q == StIdle && INPUT_DATA_ENABLE) in_d = INPUT_DATA;
        if (state_q == StRow) begin
            for (int n = 0; n < 8; n++) tbuf_d[n][cnt_q] = res[n];
        end
        if (state_q == StCol) begin
            for (int n = 0; n < 8; n++) out_d[n][cnt_q] = res[n];
        end
    end

    // Outputs decoded from state.
    always_comb begin
        INPUT_READY        = (state_q == StIdle);
        OUTPUT_DATA_ENABLE = (state_q == StDone);
        OUTPUT_DATA        = out_q;
    end

endmodule

// File: tb/tb_idct_2d.sv
// tb_idct_2d: directed and random checks of idct_2d against a fixed-point model.
// The model builds its cosine table from real arithmetic.
module tb_idct_2d;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic        oen;
    logic [31:0] din  [8][8];
    logic [31:0] dout [8][8];

    logic [31:0] m_in  [8][8];
    logic [31:0] m_out [8][8];
    longint      ctab  [8][8];
    int          n_checks;
    int          n_fail;
    int          lat;
    int          pulses;

    idct_2d dut (
        .CLOCK              (clk),
        .RESET              (rst_n),
        .INPUT_DATA_ENABLE  (en),
        .INPUT_READY        (rdy),
        .INPUT_DATA         (din),
        .OUTPUT_DATA_ENABLE (oen),
        .OUTPUT_DATA        (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic build_table();
        real pi, c, v;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? (1.0 / $sqrt(8.0)) : 0.5;
                v = 4096.0 * c * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                ctab[k][n] = longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
            end
        end
    endtask

    // Golden model: m_in[v][u] -> m_out[y][x].
    task automatic model();
        logic [31:0] t [8][8];
        longint s;
        longint r;
        for (int v = 0; v < 8; v++) begin
            for (int x = 0; x < 8; x++) begin
                s = 0;
                for (int u = 0; u < 8; u++) s += longint'($signed(m_in[v][u])) * ctab[u][x];
                r = (s + 2048) >>> 12;
                t[x][v] = r[31:0];
            end
        end
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                s = 0;
                for (int v = 0; v < 8; v++) s += longint'($signed(t[x][v])) * ctab[v][y];
                r = (s + 2048) >>> 12;
                r = longint'($signed(r[31:0]));
`ifdef IDCT_CLIP_EN
                if (r > 1023) r = 1023;
                if (r < -1024) r = -1024;
`endif
                m_out[y][x] = r[31:0];
            end
        end
    endtask

    task automatic fill_exp(input logic [31:0] val);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_out[i][j] = val;
    endtask

    task automatic check_out(input string tag);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                chk($sformatf("%s_out[%0d][%0d]", tag, y, x), dout[y][x], m_out[y][x]);
            end
        end
    endtask

    // Present m_in with one enable cycle. Returns at the negedge after the capture edge E0.
    task automatic send(input string tag);
        din = m_in;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        chk({tag, "_ready_drop"}, {31'd0, rdy}, 32'd1 - 32'd1);
    endtask

    // Waits for the pulse. lat counts edges after E0, and start is the edges already elapsed.
    task automatic wait_pulse(input int start);
        lat = -1;
        for (int i = start + 1; i <= start + 40; i++) begin
            @(negedge clk);
            if (oen === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic no_pulse(input int cycles);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (oen !== 1'b0) pulses++;
        end
    endtask

    task automatic run_dc(input string tag, input logic [31:0] dc, input logic [31:0] expv);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_in[i][j] = '0;
        m_in[0][0] = dc;
        send(tag);
        wait_pulse(0);
        chk({tag, "_latency"}, lat, 32'd16);
        fill_exp(expv);
        check_out(tag);
        @(negedge clk);
        chk({tag, "_pulse_width"}, {31'd0, oen}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, rdy}, 32'd1);
    endtask

    task automatic rand_block();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) m_in[i][j] = 32'($urandom_range(0, 65534)) - 32'd32767;
        end
    endtask

    initial begin
        logic [31:0] blk_b [8][8];
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) din[i][j] = '0;
        build_table();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, rdy}, 32'd1);
        chk("reset_oen", {31'd0, oen}, 32'd0);
        fill_exp(32'd0);
        check_out("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // DC cases with hand-computed values.
        run_dc("dc_pos", 32'd64, 32'd8);
        run_dc("dc_neg", -32'sd64, -32'sd8);
        run_dc("zero", 32'd0, 32'd0);

        // Busy: an enable at E0+5 is ignored.
        rand_block();
        rand_block();
        blk_b = m_in;
        rand_block();
        model();
        send("busy");
        repeat (4) @(negedge clk);
        din = blk_b;
        en  = 1'b1;
        @(negedge clk) en = 1'b0;
        wait_pulse(5);
        chk("busy_latency", lat, 32'd16);
        check_out("busy_a");
        // Enable held during DONE is also ignored.
        en = 1'b1;
        @(negedge clk) en = 1'b0;
        chk("done_en_ready", {31'd0, rdy}, 32'd1);
        no_pulse(25);
        chk("done_en_no_pulse", pulses, 32'd0);
        m_in = blk_b;
        model();
        send("busy_b");
        wait_pulse(0);
        chk("busy_b_latency", lat, 32'd16);
        check_out("busy_b");

        // Reset mid-operation.
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_in[i][j] = '0;
        m_in[0][0] = 32'd64;
        @(negedge clk);
        send("rst_mid");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, rdy}, 32'd1);
        chk("rst_mid_oen", {31'd0, oen}, 32'd0);
        fill_exp(32'd0);
        check_out("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        no_pulse(25);
        chk("rst_mid_no_pulse", pulses, 32'd0);
        run_dc("after_rst", 32'd64, 32'd8);

        // Large DC: saturates when clipping is built in.
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_in[i][j] = '0;
        m_in[0][0] = 32'd32767;
        model();
`ifdef IDCT_CLIP_EN
        fill_exp(32'd1023);
`endif
        send("clip");
        wait_pulse(0);
        chk("clip_latency", lat, 32'd16);
        check_out("clip");
        @(negedge clk);

        // Random blocks against the model.
        for (int b = 0; b < 1000; b++) begin
            rand_block();
            model();
            send($sformatf("rnd%0d", b));
            wait_pulse(0);
            chk($sformatf("rnd%0d_latency", b), lat, 32'd16);
            check_out($sformatf("rnd%0d", b));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
